// File: rtl/tdc_fifo_pkg.sv
// Shared types and helpers for the TDC merging-stage FIFO.
// The FWFT prefetch states and the drop counter width live here so that every FIFO file agrees on them.
package tdc_fifo_pkg;

    localparam int DROP_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2
    } fwft_state_t;

    // Ceiling log2. It is written as a loop so that it also works when it is evaluated as a constant.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/tdc_fifo_ram.sv
// Simple dual-port RAM for the TDC FIFO. It has one write port and one registered read port with a read enable.
// The read register clears on reset, so the FIFO output starts at zero.
module tdc_fifo_ram
    import tdc_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 512,
    localparam int ADDR_W    = clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_we,
    input  logic [ADDR_W-1:0]     i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_re,
    input  logic [ADDR_W-1:0]     i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/tdc_sync_fifo.sv
// Single-clock timestamp FIFO with a standard or first-word-fall-through read mode.
// It also provides an occupancy count, threshold flags, error pulses and a saturating count of dropped writes.
module tdc_sync_fifo
    import tdc_fifo_pkg::*;
#(
    parameter int DATA_WIDTH          = 32,
    parameter int DEPTH_LOG2          = 9,
    parameter int ALMOST_FULL_OFFSET  = 128,
    parameter int ALMOST_EMPTY_OFFSET = 128,
    parameter int FWFT                = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  WriteEN,
    input  logic [DATA_WIDTH-1:0] data_input,
    input  logic                  ReadEN,
    output logic [DATA_WIDTH-1:0] data_output,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  writeERR,
    output logic                  readERR,
    output logic [DROP_CNT_W-1:0] drop_count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = DEPTH_LOG2 + 1;
    localparam logic [PW-1:0] DEPTH_C  = PW'(DEPTH);
    localparam logic [PW-1:0] AF_LEVEL = PW'(DEPTH - ALMOST_FULL_OFFSET);
    localparam logic [PW-1:0] AE_LEVEL = PW'(ALMOST_EMPTY_OFFSET);

    logic [PW-1:0]         r_wrPtr;
    logic [PW-1:0]         r_rdPtr;
    logic [PW-1:0]         r_count;
    logic [DROP_CNT_W-1:0] r_dropCount;
    logic                  r_writeErr;
    logic                  r_readErr;
    fwft_state_t           r_state;

    logic          w_full;
    logic          w_empty;
    logic          w_wrAccept;
    logic          w_rdAccept;
    logic          w_ramRead;
    logic          w_ramNonEmpty;
    logic [PW-1:0] w_ramCount;

    // The RAM can hold fewer words than the FIFO count, because in FWFT mode the head word may already have left the RAM.
    assign w_ramCount    = r_wrPtr - r_rdPtr;
    assign w_ramNonEmpty = (w_ramCount != '0);
    assign w_full        = (r_count == DEPTH_C);
    assign w_empty       = (FWFT != 0) ? (r_state != VALID) : (r_count == '0);
    assign w_wrAccept    = WriteEN && !w_full;
    assign w_rdAccept    = ReadEN && !w_empty;

    // A pop in VALID with more words queued refills the output on the same edge. This keeps one word per clock.
    always_comb begin
        w_ramRead = 1'b0;
        if (FWFT != 0) begin
            case (r_state)
                IDLE:    w_ramRead = w_ramNonEmpty;
                VALID:   w_ramRead = w_rdAccept && w_ramNonEmpty;
                default: w_ramRead = 1'b0;
            endcase
        end else begin
            w_ramRead = w_rdAccept;
        end
    end

    tdc_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_wrAccept),
        .i_waddr (r_wrPtr[DEPTH_LOG2-1:0]),
        .i_wdata (data_input),
        .i_re    (w_ramRead),
        .i_raddr (r_rdPtr[DEPTH_LOG2-1:0]),
        .o_rdata (data_output)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_wrAccept) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_ramRead) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_wrAccept, w_rdAccept})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else if (FWFT == 0) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_ramNonEmpty) begin
                        r_state <= FETCH;
                    end
                end
                FETCH: r_state <= VALID;
                VALID: begin
                    if (w_rdAccept && !w_ramNonEmpty) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_writeErr  <= 1'b0;
            r_readErr   <= 1'b0;
            r_dropCount <= '0;
        end else begin
            r_writeErr <= WriteEN && w_full;
            r_readErr  <= ReadEN && w_empty;
            if (WriteEN && w_full && (r_dropCount != {DROP_CNT_W{1'b1}})) begin
                r_dropCount <= r_dropCount + 1'b1;
            end
        end
    end

    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_count >= AF_LEVEL);
    assign almost_empty = (r_count <= AE_LEVEL);
    assign count        = r_count;
    assign writeERR     = r_writeErr;
    assign readERR      = r_readErr;
    assign drop_count   = r_dropCount;

endmodule
